// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard controller: instruction classes, FSM states,
// forward-select codes and a small register-match helper.
package hazard_unit_pkg;

  typedef enum logic [2:0] {
    ALU     = 3'd0,
    ALU_IMM = 3'd1,
    LOAD    = 3'd2,
    STORE   = 3'd3,
    BRANCH  = 3'd4,
    JUMP    = 3'd5,
    UPPER   = 3'd6,
    SYSTEM  = 3'd7
  } InstructionTypes;

  typedef enum logic {
    IDLE     = 1'b0,
    MDU_BUSY = 1'b1
  } HazardState_t;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_ALU_M = 2'b01;
  localparam logic [1:0] FWD_RES_W = 2'b10;
  localparam logic [1:0] FWD_UPPER = 2'b11;

  // x0 is hardwired to zero, so a write to it never produces a usable value
  function automatic logic reg_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_unit_forward_select.sv
// Per-operand forwarding priority: memory stage beats writeback, upper-immediate
// producers get their own mux leg.
module forward_select
  import hazard_unit_pkg::*;
(
  input  logic [4:0]      rs_i,
  input  logic [4:0]      rd_m_i,
  input  logic [4:0]      rd_w_i,
  input  logic            reg_write_m_i,
  input  logic            reg_write_w_i,
  input  InstructionTypes type_m_i,
  input  InstructionTypes type_w_i,
  output logic [1:0]      fwd_sel_o
);

  always_comb begin
    fwd_sel_o = FWD_REG;
    if (reg_hit(reg_write_m_i, rd_m_i, rs_i)) begin
      fwd_sel_o = (type_m_i == UPPER) ? FWD_UPPER : FWD_ALU_M;
    end else if (reg_hit(reg_write_w_i, rd_w_i, rs_i)) begin
      fwd_sel_o = (type_w_i == UPPER) ? FWD_UPPER : FWD_RES_W;
    end else begin
      fwd_sel_o = FWD_REG;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32 core: operand forwarding, load-use stall,
// taken-branch flush, multi-cycle MDU stall FSM with timeout, and performance counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       iRs1D,
  input  logic [4:0]       iRs2D,
  input  logic [4:0]       iRs1E,
  input  logic [4:0]       iRs2E,
  input  logic [4:0]       iRdE,
  input  logic [4:0]       iRdM,
  input  logic [4:0]       iRdW,
  input  logic             iRegWriteE,
  input  logic             iRegWriteM,
  input  logic             iRegWriteW,
  input  InstructionTypes  iInstructionTypeE,
  input  InstructionTypes  iInstructionTypeM,
  input  InstructionTypes  iInstructionTypeW,
  input  logic             iBranchTakenE,
  input  logic             iMduStartE,
  input  logic             iMduDoneE,
  output logic [1:0]       oForwardAluOp1,
  output logic [1:0]       oForwardAluOp2,
  output logic             oStallF,
  output logic             oStallD,
  output logic             oStallE,
  output logic             oFlushD,
  output logic             oFlushE,
  output logic             oMduTimeout,
  output logic [CNT_W-1:0] oStallCount,
  output logic [CNT_W-1:0] oFlushCount
);

  localparam int unsigned TW = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(MDU_TIMEOUT - 1);

  HazardState_t      state_q, state_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic enter_busy, mdu_stall, load_use, branch_flush;

  forward_select u_fwd_op1 (
    .rs_i(iRs1E), .rd_m_i(iRdM), .rd_w_i(iRdW),
    .reg_write_m_i(iRegWriteM), .reg_write_w_i(iRegWriteW),
    .type_m_i(iInstructionTypeM), .type_w_i(iInstructionTypeW),
    .fwd_sel_o(oForwardAluOp1)
  );

  forward_select u_fwd_op2 (
    .rs_i(iRs2E), .rd_m_i(iRdM), .rd_w_i(iRdW),
    .reg_write_m_i(iRegWriteM), .reg_write_w_i(iRegWriteW),
    .type_m_i(iInstructionTypeM), .type_w_i(iInstructionTypeW),
    .fwd_sel_o(oForwardAluOp2)
  );

  // The issuing cycle already holds E so the MDU op stays put until its result returns
  assign enter_busy   = (state_q == IDLE) && iMduStartE && !iBranchTakenE && !iMduDoneE;
  assign mdu_stall    = enter_busy || ((state_q == MDU_BUSY) && !iMduDoneE);
  assign load_use     = (state_q == IDLE) && (iInstructionTypeE == LOAD) &&
                        (reg_hit(iRegWriteE, iRdE, iRs1D) || reg_hit(iRegWriteE, iRdE, iRs2D));
  assign branch_flush = (state_q == IDLE) && iBranchTakenE;

  assign oStallF     = mdu_stall || (load_use && !branch_flush);
  assign oStallD     = oStallF;
  assign oStallE     = mdu_stall;
  assign oFlushD     = branch_flush;
  assign oFlushE     = branch_flush || (load_use && !mdu_stall);
  assign oMduTimeout = timeout_q;
  assign oStallCount = stall_cnt_q;
  assign oFlushCount = flush_cnt_q;

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enter_busy) begin
          state_d = MDU_BUSY;
          tcnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      MDU_BUSY: begin
        if (iMduDoneE) begin
          state_d = IDLE;
        end else if (tcnt_q == TCNT_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (oStallF && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (oFlushD && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
